imuldiv_muldiv_dispatch: RTL and testbench

- Front end for the iterative multiply and divide units. Accepts one muldiv request stream and routes each operation to the mul unit or the div unit.
- Tracks issue order so responses return strictly in request order, even with both units busy.
- Sits directly upstream of the iterative divider, driving its divreq interface, and directly downstream of its divresp interface. Adds zero cycles of latency on either path.

---
 rtl/imuldiv_muldiv_dispatch_pkg.sv | 49 ++++
 rtl/imuldiv_muldiv_dispatch_order_queue.sv | 58 +++++
 rtl/imuldiv_muldiv_dispatch.sv | 131 +++++++++++++
 tb/tb_imuldiv_muldiv_dispatch.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imuldiv_muldiv_dispatch_pkg.sv
// Shared muldiv encodings: request fn codes, divider signed/unsigned codes and unit ids.
// Optional macro IMULDIV_DISPATCH_RESULT_SEL_EN widens the order-queue tag to the full fn.
package imuldiv_muldiv_dispatch_pkg;

    localparam logic [2:0] IMULDIV_MULDIVREQ_MSG_FUNC_MUL  = 3'd0;
    localparam logic [2:0] IMULDIV_MULDIVREQ_MSG_FUNC_DIV  = 3'd1;
    localparam logic [2:0] IMULDIV_MULDIVREQ_MSG_FUNC_DIVU = 3'd2;
    localparam logic [2:0] IMULDIV_MULDIVREQ_MSG_FUNC_REM  = 3'd3;
    localparam logic [2:0] IMULDIV_MULDIVREQ_MSG_FUNC_REMU = 3'd4;

    localparam logic IMULDIV_DIVREQ_MSG_FUNC_SIGNED   = 1'b0;
    localparam logic IMULDIV_DIVREQ_MSG_FUNC_UNSIGNED = 1'b1;

    typedef enum logic [1:0] {
        UNIT_MUL = 2'd0,
        UNIT_DIV = 2'd1,
        UNIT_ERR = 2'd2
    } unit_e;

`ifdef IMULDIV_DISPATCH_RESULT_SEL_EN
    localparam int TAG_W = 3;
`else
    localparam int TAG_W = 2;
`endif

    function automatic unit_e fn_to_unit(input logic [2:0] fn);
        unit_e u;
        case (fn)
            IMULDIV_MULDIVREQ_MSG_FUNC_MUL:  u = UNIT_MUL;
            IMULDIV_MULDIVREQ_MSG_FUNC_DIV,
            IMULDIV_MULDIVREQ_MSG_FUNC_DIVU,
            IMULDIV_MULDIVREQ_MSG_FUNC_REM,
            IMULDIV_MULDIVREQ_MSG_FUNC_REMU: u = UNIT_DIV;
            default:                         u = UNIT_ERR;
        endcase
        return u;
    endfunction

    function automatic logic fn_to_divfn(input logic [2:0] fn);
        logic d;
        case (fn)
            IMULDIV_MULDIVREQ_MSG_FUNC_DIV,
            IMULDIV_MULDIVREQ_MSG_FUNC_REM: d = IMULDIV_DIVREQ_MSG_FUNC_SIGNED;
            default:                        d = IMULDIV_DIVREQ_MSG_FUNC_UNSIGNED;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imuldiv_muldiv_dispatch_order_queue.sv
// Tag FIFO recording which unit owns each outstanding operation, oldest at the head.
module imuldiv_DispatchOrderQueue #(
    parameter int DEPTH = 2,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == (PTR_W+1)'(DEPTH));
    assign empty     = (count_r == (PTR_W+1)'(0));
    assign head_data = mem_r[rd_ptr_r];

    // A full queue refuses the push even when the head is leaving this cycle.
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/imuldiv_muldiv_dispatch.sv
// Routes muldiv requests to the mul or div unit and returns responses in issue order.
// Define IMULDIV_DISPATCH_RESULT_SEL_EN to format the result (quotient/remainder select).
module imuldiv_muldiv_dispatch
    import imuldiv_muldiv_dispatch_pkg::*;
#(
    parameter int ORDQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  muldivreq_msg_fn,
    input  logic [31:0] muldivreq_msg_a,
    input  logic [31:0] muldivreq_msg_b,
    input  logic        muldivreq_val,
    output logic        muldivreq_rdy,
    output logic [63:0] muldivresp_msg_result,
    output logic        muldivresp_val,
    input  logic        muldivresp_rdy,
    output logic [31:0] mulreq_msg_a,
    output logic [31:0] mulreq_msg_b,
    output logic        mulreq_val,
    input  logic        mulreq_rdy,
    input  logic [63:0] mulresp_msg_result,
    input  logic        mulresp_val,
    output logic        mulresp_rdy,
    output logic        divreq_msg_fn,
    output logic [31:0] divreq_msg_a,
    output logic [31:0] divreq_msg_b,
    output logic        divreq_val,
    input  logic        divreq_rdy,
    input  logic [63:0] divresp_msg_result,
    input  logic        divresp_val,
    output logic        divresp_rdy
);

    unit_e             req_unit_s;
    unit_e             head_unit_s;
    logic [TAG_W-1:0]  push_tag_s;
    logic [TAG_W-1:0]  head_tag_s;
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic              tgt_rdy_s;
    logic              unit_val_s;
    logic [63:0]       raw_result_s;

    assign mulreq_msg_a  = muldivreq_msg_a;
    assign mulreq_msg_b  = muldivreq_msg_b;
    assign divreq_msg_a  = muldivreq_msg_a;
    assign divreq_msg_b  = muldivreq_msg_b;
    assign divreq_msg_fn = fn_to_divfn(muldivreq_msg_fn);
    assign req_unit_s    = fn_to_unit(muldivreq_msg_fn);

`ifdef IMULDIV_DISPATCH_RESULT_SEL_EN
    assign push_tag_s  = muldivreq_msg_fn;
    assign head_unit_s = fn_to_unit(head_tag_s);
`else
    assign push_tag_s  = TAG_W'(req_unit_s);
    assign head_unit_s = unit_e'(head_tag_s);
`endif

    // Request side: handshake with the target unit; illegal fns only need a free queue slot.
    always_comb begin
        tgt_rdy_s = 1'b0;
        case (req_unit_s)
            UNIT_MUL: tgt_rdy_s = mulreq_rdy;
            UNIT_DIV: tgt_rdy_s = divreq_rdy;
            default:  tgt_rdy_s = 1'b1;
        endcase
        muldivreq_rdy = reset && !full_s && tgt_rdy_s;
        mulreq_val    = reset && muldivreq_val && !full_s && (req_unit_s == UNIT_MUL);
        divreq_val    = reset && muldivreq_val && !full_s && (req_unit_s == UNIT_DIV);
        push_s        = muldivreq_val && muldivreq_rdy;
    end

    // Response side: only the unit named by the head tag may hand its result over.
    always_comb begin
        unit_val_s   = 1'b0;
        raw_result_s = 64'h0;
        case (head_unit_s)
            UNIT_MUL: begin
                unit_val_s   = mulresp_val;
                raw_result_s = mulresp_msg_result;
            end
            UNIT_DIV: begin
                unit_val_s   = divresp_val;
                raw_result_s = divresp_msg_result;
            end
            default: begin
                unit_val_s   = 1'b1;
                raw_result_s = 64'h0;
            end
        endcase
        muldivresp_val = reset && !empty_s && unit_val_s;
        mulresp_rdy    = reset && muldivresp_rdy && !empty_s && (head_unit_s == UNIT_MUL);
        divresp_rdy    = reset && muldivresp_rdy && !empty_s && (head_unit_s == UNIT_DIV);
        pop_s          = muldivresp_val && muldivresp_rdy;
    end

    // Result formatting; the divider packs {remainder, quotient}.
    always_comb begin
        muldivresp_msg_result = 64'h0;
`ifdef IMULDIV_DISPATCH_RESULT_SEL_EN
        case (head_tag_s)
            IMULDIV_MULDIVREQ_MSG_FUNC_MUL:  muldivresp_msg_result = raw_result_s;
            IMULDIV_MULDIVREQ_MSG_FUNC_DIV,
            IMULDIV_MULDIVREQ_MSG_FUNC_DIVU: muldivresp_msg_result = {32'h0, raw_result_s[31:0]};
            IMULDIV_MULDIVREQ_MSG_FUNC_REM,
            IMULDIV_MULDIVREQ_MSG_FUNC_REMU: muldivresp_msg_result = {32'h0, raw_result_s[63:32]};
            default:                         muldivresp_msg_result = 64'h0;
        endcase
`else
        muldivresp_msg_result = raw_result_s;
`endif
    end

    imuldiv_DispatchOrderQueue #(
        .DEPTH (ORDQ_DEPTH),
        .W     (TAG_W)
    ) u_ordq (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_tag_s),
        .pop       (pop_s),
        .head_data (head_tag_s),
        .full      (full_s),
        .empty     (empty_s)
    );

endmodule

// File: tb/tb_imuldiv_muldiv_dispatch.sv
// Bench for imuldiv_muldiv_dispatch: directed scenarios, then randomized traffic against
// a request-order scoreboard fed by an arithmetic reference model, with emulated mul/div units.
module tb_imuldiv_muldiv_dispatch;
    import imuldiv_muldiv_dispatch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  muldivreq_msg_fn;
    logic [31:0] muldivreq_msg_a, muldivreq_msg_b;
    logic        muldivreq_val, muldivreq_rdy;
    logic [63:0] muldivresp_msg_result;
    logic        muldivresp_val, muldivresp_rdy;
    logic [31:0] mulreq_msg_a, mulreq_msg_b;
    logic        mulreq_val, mulreq_rdy;
    logic [63:0] mulresp_msg_result;
    logic        mulresp_val, mulresp_rdy;
    logic        divreq_msg_fn;
    logic [31:0] divreq_msg_a, divreq_msg_b;
    logic        divreq_val, divreq_rdy;
    logic [63:0] divresp_msg_result;
    logic        divresp_val, divresp_rdy;

    always #5 clk = ~clk;

    imuldiv_muldiv_dispatch #(.ORDQ_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
        .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val),
        .muldivreq_rdy(muldivreq_rdy), .muldivresp_msg_result(muldivresp_msg_result),
        .muldivresp_val(muldivresp_val), .muldivresp_rdy(muldivresp_rdy),
        .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b),
        .mulreq_val(mulreq_val), .mulreq_rdy(mulreq_rdy),
        .mulresp_msg_result(mulresp_msg_result), .mulresp_val(mulresp_val),
        .mulresp_rdy(mulresp_rdy), .divreq_msg_fn(divreq_msg_fn),
        .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
        .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
        .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val),
        .divresp_rdy(divresp_rdy)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];
    logic req_fired = 1'b0;

    // emulated units: one operation in flight each, result held until taken
    logic        mul_busy = 1'b0, div_busy = 1'b0;
    logic        mul_stall = 1'b0, div_stall = 1'b0;
    int          mul_cnt = 0, div_cnt = 0, mul_lat = 1, div_lat = 3;
    logic [63:0] mul_res = 64'h0, div_res = 64'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [2:0] fn, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        sa = a;
        sb = b;
        q  = 32'h0;
        r  = 32'h0;
        if (fn == 3'd0) return {32'h0, a} * {32'h0, b};
        if (fn > 3'd4)  return 64'h0;
        if (fn == 3'd1 || fn == 3'd3) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
`ifdef IMULDIV_DISPATCH_RESULT_SEL_EN
        if (fn == 3'd1 || fn == 3'd2) return {32'h0, q};
        return {32'h0, r};
`else
        return {r, q};
`endif
    endfunction

    function automatic logic exp_divfn(input logic [2:0] fn);
        return (fn == 3'd1 || fn == 3'd3) ? IMULDIV_DIVREQ_MSG_FUNC_SIGNED
                                          : IMULDIV_DIVREQ_MSG_FUNC_UNSIGNED;
    endfunction

    task automatic drive_units();
        mulreq_rdy         = !mul_busy && !mul_stall;
        mulresp_val        = mul_busy && (mul_cnt == 0);
        mulresp_msg_result = mul_busy ? mul_res : 64'h0;
        divreq_rdy         = !div_busy && !div_stall;
        divresp_val        = div_busy && (div_cnt == 0);
        divresp_msg_result = div_busy ? div_res : 64'h0;
    endtask

    task automatic cycle();
        logic f_req, f_mreq, f_dreq, f_mresp, f_dresp, f_resp, dfn;
        logic [31:0] ma, mb, da, db, q, r;
        logic signed [31:0] sa, sb;
        @(negedge clk);
        f_req   = muldivreq_val && muldivreq_rdy;
        f_mreq  = mulreq_val && mulreq_rdy;
        f_dreq  = divreq_val && divreq_rdy;
        f_mresp = mulresp_val && mulresp_rdy;
        f_dresp = divresp_val && divresp_rdy;
        f_resp  = muldivresp_val && muldivresp_rdy;
        ma = mulreq_msg_a; mb = mulreq_msg_b;
        da = divreq_msg_a; db = divreq_msg_b; dfn = divreq_msg_fn;
        if (f_req) begin
            exp_q.push_back(ref_result(muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b));
            chk("route_mul", f_mreq, muldivreq_msg_fn == 3'd0);
            chk("route_div", f_dreq, muldivreq_msg_fn inside {[3'd1:3'd4]});
        end
        if (f_dreq) begin
            chk("div_fn", dfn, exp_divfn(muldivreq_msg_fn));
            chk("div_b", db, muldivreq_msg_b);
        end
        if (f_mreq) chk("mul_a", ma, muldivreq_msg_a);
        if (f_resp) begin
            if (exp_q.size() == 0) chk("resp_unexpected", muldivresp_val, 1'b0);
            else chk("resp_order", muldivresp_msg_result, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        req_fired = f_req;
        if (f_mresp) mul_busy = 1'b0;
        if (f_mreq) begin
            mul_busy = 1'b1;
            mul_cnt  = mul_lat;
            mul_res  = {32'h0, ma} * {32'h0, mb};
        end else if (mul_busy && mul_cnt > 0) mul_cnt--;
        if (f_dresp) div_busy = 1'b0;
        if (f_dreq) begin
            sa = da; sb = db;
            if (dfn == IMULDIV_DIVREQ_MSG_FUNC_SIGNED) begin
                q = sa / sb; r = sa % sb;
            end else begin
                q = da / db; r = da % db;
            end
            div_busy = 1'b1;
            div_cnt  = div_lat;
            div_res  = {r, q};
        end else if (div_busy && div_cnt > 0) div_cnt--;
        drive_units();
        #1;
    endtask

    task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        int i;
        i = 0;
        muldivreq_msg_fn = fn; muldivreq_msg_a = a; muldivreq_msg_b = b; muldivreq_val = 1'b1;
        #1;
        while (!muldivreq_rdy && i < 50) begin cycle(); i++; end
        chk("issue_rdy", muldivreq_rdy, 1'b1);
        cycle();
        muldivreq_val = 1'b0;
        #1;
    endtask

    task automatic wait_resp(input string tag);
        int i;
        i = 0;
        while (!muldivresp_val && i < 60) begin cycle(); i++; end
        chk(tag, muldivresp_val, 1'b1);
    endtask

    task automatic drain();
        int i;
        i = 0;
        muldivresp_rdy = 1'b1;
        while (exp_q.size() > 0 && i < 400) begin cycle(); i++; end
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held;
        reset = 1'b0;
        muldivreq_msg_fn = 3'd0; muldivreq_msg_a = 32'd1; muldivreq_msg_b = 32'd1;
        muldivreq_val = 1'b1; muldivresp_rdy = 1'b1;
        drive_units();
        #2;
        chk("rst_req_rdy", muldivreq_rdy, 1'b0);
        chk("rst_mulreq_val", mulreq_val, 1'b0);
        chk("rst_resp_val", muldivresp_val, 1'b0);
        muldivreq_val = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("idle_resp_val", muldivresp_val, 1'b0);

        // MUL 6*7
        mul_lat = 2;
        muldivreq_msg_fn = 3'd0; muldivreq_msg_a = 32'd6; muldivreq_msg_b = 32'd7;
        muldivreq_val = 1'b1;
        #1;
        chk("mul_val_up", mulreq_val, 1'b1);
        cycle();
        muldivreq_val = 1'b0;
        #1;
        chk("mul_val_pulse", mulreq_val, 1'b0);
        wait_resp("mul_resp_wait");
        chk("mul_42", muldivresp_msg_result, 64'd42);
        cycle();
        chk("mul_empty", muldivresp_val, 1'b0);

        // DIV -7/2 and REM -7/2
        muldivreq_msg_fn = 3'd1; muldivreq_msg_a = 32'hFFFFFFF9; muldivreq_msg_b = 32'd2;
        muldivreq_val = 1'b1;
        #1;
        chk("div_signed_fn", divreq_msg_fn, IMULDIV_DIVREQ_MSG_FUNC_SIGNED);
        issue(3'd1, 32'hFFFFFFF9, 32'd2);
        wait_resp("div_wait");
`ifdef IMULDIV_DISPATCH_RESULT_SEL_EN
        chk("div_neg", muldivresp_msg_result, {32'h0, 32'hFFFFFFFD});
`else
        chk("div_neg", muldivresp_msg_result, {32'hFFFFFFFF, 32'hFFFFFFFD});
`endif
        cycle();
        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        wait_resp("rem_wait");
`ifdef IMULDIV_DISPATCH_RESULT_SEL_EN
        chk("rem_neg", muldivresp_msg_result, {32'h0, 32'hFFFFFFFF});
`else
        chk("rem_neg", muldivresp_msg_result, {32'hFFFFFFFF, 32'hFFFFFFFD});
`endif
        cycle();

        // DIV 100/7 then MUL 3*5; mul finishes first but must wait
        div_lat = 8; mul_lat = 1;
        issue(3'd1, 32'd100, 32'd7);
        issue(3'd0, 32'd3, 32'd5);
        muldivreq_msg_fn = 3'd6; muldivreq_val = 1'b1;
        #1;
        chk("full_blocks", muldivreq_rdy, 1'b0);
        muldivreq_val = 1'b0;
        for (int i = 0; i < 10 && !mulresp_val; i++) cycle();
        chk("mul_done_first", mulresp_val, 1'b1);
        chk("mul_held", mulresp_rdy, 1'b0);
        chk("no_early_resp", muldivresp_val, 1'b0);
        wait_resp("ord_div_wait");
`ifdef IMULDIV_DISPATCH_RESULT_SEL_EN
        chk("ord_div", muldivresp_msg_result, {32'd0, 32'd14});
`else
        chk("ord_div", muldivresp_msg_result, {32'd2, 32'd14});
`endif
        cycle();
        wait_resp("ord_mul_wait");
        chk("ord_mul", muldivresp_msg_result, 64'd15);
        cycle();

        // illegal fn behind a MUL
        mul_lat = 3;
        issue(3'd0, 32'd9, 32'd9);
        muldivreq_msg_fn = 3'd6; muldivreq_msg_a = 32'd1; muldivreq_msg_b = 32'd1;
        muldivreq_val = 1'b1;
        #1;
        chk("err_no_div", divreq_val, 1'b0);
        chk("err_rdy", muldivreq_rdy, 1'b1);
        cycle();
        muldivreq_val = 1'b0;
        wait_resp("err_mul_wait");
        chk("err_mul_first", muldivresp_msg_result, 64'd81);
        cycle();
        wait_resp("err_wait");
        chk("err_zero", muldivresp_msg_result, 64'h0);
        cycle();

        // back-pressure with a div result pending
        div_lat = 1;
        muldivresp_rdy = 1'b0;
        issue(3'd2, 32'd50, 32'd5);
        wait_resp("bp_wait");
        held = muldivresp_msg_result;
        chk("bp_value", held, {32'd0, 32'd10});
        for (int i = 0; i < 10; i++) begin
            chk("bp_val", muldivresp_val, 1'b1);
            chk("bp_stable", muldivresp_msg_result, held);
            chk("bp_divrdy", divresp_rdy, 1'b0);
            cycle();
        end
        muldivresp_rdy = 1'b1;
        #1;
        chk("bp_release", divresp_rdy, 1'b1);
        cycle();
        chk("bp_single_pop", muldivresp_val, 1'b0);

        // reset in the middle of a division
        div_lat = 20;
        issue(3'd1, 32'd1000, 32'd3);
        cycle();
        muldivreq_msg_fn = 3'd0; muldivreq_val = 1'b1;
        reset = 1'b0;
        #1;
        chk("mr_req_rdy", muldivreq_rdy, 1'b0);
        chk("mr_mulreq_val", mulreq_val, 1'b0);
        chk("mr_divreq_val", divreq_val, 1'b0);
        chk("mr_resp_val", muldivresp_val, 1'b0);
        chk("mr_mulresp_rdy", mulresp_rdy, 1'b0);
        chk("mr_divresp_rdy", divresp_rdy, 1'b0);
        muldivreq_val = 1'b0;
        mul_busy = 1'b0; div_busy = 1'b0;
        exp_q.delete();
        drive_units();
        cycle();
        reset = 1'b1;
        #1;
        chk("mr_empty", muldivresp_val, 1'b0);
        mul_lat = 1;
        issue(3'd0, 32'd2, 32'd2);
        wait_resp("mr_mul_wait");
        chk("mr_mul_4", muldivresp_msg_result, 64'd4);
        cycle();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            mul_stall = ($urandom_range(0, 3) == 0);
            div_stall = ($urandom_range(0, 3) == 0);
            mul_lat   = $urandom_range(0, 4);
            div_lat   = $urandom_range(0, 6);
            muldivresp_rdy = ($urandom_range(0, 3) != 0);
            if (!muldivreq_val || req_fired) begin
                muldivreq_val    = ($urandom_range(0, 2) != 0);
                muldivreq_msg_fn = 3'($urandom_range(0, 7));
                muldivreq_msg_a  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
                muldivreq_msg_b  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
                if (muldivreq_msg_b == 32'd0) muldivreq_msg_b = 32'd1;
                if (muldivreq_msg_a == 32'h80000000 && muldivreq_msg_b == 32'hFFFFFFFF)
                    muldivreq_msg_b = 32'd3;
            end
            drive_units();
            #1;
            cycle();
        end
        muldivreq_val = 1'b0;
        mul_stall = 1'b0; div_stall = 1'b0;
        drive_units();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
